// File: rtl/mem_bus_master.sv
// Avalon-MM word initiator for the CPU core: one load/store/fetch at a time,
// with lane steering, byteenables, wait-state handling and load extension.
module mem_bus_master #(
    parameter int unsigned MAX_WAIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic        cmd_signed,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_error,
    output logic [31:0] rsp_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RDATA} state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d, sgn_q, sgn_d;
    logic [1:0]        size_q, size_d, lane_q, lane_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [31:0]       address_q, address_d, writedata_q, writedata_d;
    logic              read_q, read_d, write_q, write_d;
    logic [3:0]        byteenable_q, byteenable_d;

    logic              bad_c;
    logic [3:0]        be_c;
    logic [31:0]       wd_c, shifted_c, load_c;

    // Command decode: alignment check, lane enables and store-data replication.
    always_comb begin
        bad_c = 1'b0;
        be_c  = 4'b1111;
        wd_c  = cmd_wdata;
        unique case (cmd_size)
            2'd0: begin
                be_c = 4'(4'b0001 << cmd_addr[1:0]);
                wd_c = {4{cmd_wdata[7:0]}};
            end
            2'd1: begin
                bad_c = cmd_addr[0];
                be_c  = cmd_addr[1] ? 4'b1100 : 4'b0011;
                wd_c  = {2{cmd_wdata[15:0]}};
            end
            2'd2: bad_c = (cmd_addr[1:0] != 2'b00);
            default: bad_c = 1'b1;
        endcase
    end

    // Load extraction from the latched lane offset.
    always_comb begin
        shifted_c = readdata >> {lane_q, 3'b000};
        unique case (size_q)
            2'd0:    load_c = {{24{sgn_q & shifted_c[7]}}, shifted_c[7:0]};
            2'd1:    load_c = {{16{sgn_q & shifted_c[15]}}, shifted_c[15:0]};
            default: load_c = readdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        sgn_d        = sgn_q;
        size_d       = size_q;
        lane_d       = lane_q;
        stall_d      = stall_q;
        rsp_valid_d  = 1'b0;
        rsp_error_d  = 1'b0;
        rsp_rdata_d  = 32'd0;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        read_d       = read_q;
        write_d      = write_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    wr_d   = cmd_write;
                    sgn_d  = cmd_signed;
                    size_d = cmd_size;
                    lane_d = cmd_addr[1:0];
                    if (bad_c) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        state_d      = S_BUS;
                        stall_d      = '0;
                        read_d       = ~cmd_write;
                        write_d      = cmd_write;
                        address_d    = {cmd_addr[31:2], 2'b00};
                        byteenable_d = be_c;
                        writedata_d  = wd_c;
                    end
                end
            end
            S_BUS: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    stall_d = '0;
                    if (wr_q) begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = S_RDATA;
                    end
                end else if ((MAX_WAIT != 0) && (32'(stall_q) + 32'd1 == MAX_WAIT)) begin
                    // Memory stalled too long: abandon the transaction.
                    state_d     = S_IDLE;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    stall_d     = '0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                end else begin
                    stall_d = stall_q + CNT_W'(1);
                end
            end
            S_RDATA: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_c;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            sgn_q        <= 1'b0;
            size_q       <= 2'd0;
            lane_q       <= 2'd0;
            stall_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            address_q    <= 32'd0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            sgn_q        <= sgn_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            stall_q      <= stall_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_rdata_q  <= rsp_rdata_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            read_q       <= read_d;
            write_q      <= write_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_error  = rsp_error_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign read       = read_q;
    assign write      = write_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed cases plus randomized
// commands compared against a byte-arithmetic reference model.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_signed;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata, address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_master #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_signed(cmd_signed), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
        .rsp_rdata(rsp_rdata), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest)
    );

    // Reference model: byte counts and shifts rather than per-size cases.
    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
        int nb = 1 << sz;
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int nb = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [1:0] sz, input logic sg,
                                           input logic [1:0] off, input logic [31:0] rd);
        int nb = 1 << sz;
        longint v = (longint'(rd) >> (8 * off)) & ((64'sd1 << (8 * nb)) - 1);
        if (sg && nb < 4 && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
        return 32'(v);
    endfunction

    function automatic logic exp_bad(input logic [1:0] sz, input logic [31:0] ad);
        if (sz == 2'd3) return 1'b1;
        return (ad % (32'd1 << sz)) != 0;
    endfunction

    // Drives one command from the current (IDLE) cycle and observes the bus
    // until the response; returns in the response cycle so the next call
    // presents its command back-to-back.
    task automatic do_txn(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input int nstall, input logic [31:0] rd,
                          output int rcyc, output logic rerr, output logic [31:0] rdat,
                          output logic [31:0] o_addr, output logic [3:0] o_be,
                          output logic [31:0] o_wd, output logic o_rd, output logic o_wr,
                          output int bus_cycles, output logic stable,
                          output logic rdy_at_rsp, output logic rw_at_rsp);
        cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_signed = sg;
        cmd_addr = ad; cmd_wdata = wd; waitrequest = 1'b1; readdata = $urandom;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_size = 2'($urandom);
        cmd_signed = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        rcyc = -1; rerr = 1'bx; rdat = 'x; bus_cycles = 0; stable = 1'b1;
        rdy_at_rsp = 1'b0; rw_at_rsp = 1'b1;
        o_addr = address; o_be = byteenable; o_wd = writedata; o_rd = read; o_wr = write;
        for (int k = 1; k <= 20; k++) begin
            if (read === 1'b1 || write === 1'b1) begin
                bus_cycles++;
                if (address !== o_addr || byteenable !== o_be || writedata !== o_wd ||
                    read !== o_rd || write !== o_wr) stable = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                rcyc = k; rerr = rsp_error; rdat = rsp_rdata;
                rdy_at_rsp = cmd_ready; rw_at_rsp = read | write;
                break;
            end
            waitrequest = (k <= nstall);
            readdata = (k == nstall + 2) ? rd : $urandom;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0;
        cmd_signed = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
        waitrequest = 1'b0; readdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_error, read, write} !== 5'b10000 ||
            rsp_rdata !== 32'd0 || address !== 32'd0 || byteenable !== 4'd0 ||
            writedata !== 32'd0) begin
            errors++;
            $display("FAIL reset: rdy=%b rv=%b re=%b rd=%b wr=%b rdata=%h addr=%h be=%b wd=%h, required 1 0 0 0 0 and zeros",
                     cmd_ready, rsp_valid, rsp_error, read, write, rsp_rdata, address, byteenable, writedata);
        end
    endtask

    task automatic test_store();
        int rc, bc; logic re, st, rdy, rw, ord, owr; logic [31:0] rdt, oa, ow; logic [3:0] ob;
        logic [1:0]  sz [3] = '{2'd2, 2'd0, 2'd1};
        logic [31:0] ad [3] = '{32'hBFC00010, 32'hBFC00013, 32'hBFC00012};
        logic [31:0] wd [3] = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234};
        logic [3:0]  be [3] = '{4'b1111, 4'b1000, 4'b1100};
        logic [31:0] ew [3] = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'h12341234};
        for (int i = 0; i < 3; i++) begin
            do_txn(1'b1, sz[i], 1'b0, ad[i], wd[i], 0, 32'd0, rc, re, rdt, oa, ob, ow, ord, owr, bc, st, rdy, rw);
            checks++;
            if (owr !== 1'b1 || ord !== 1'b0 || oa !== 32'hBFC00010 || ob !== be[i] || ow !== ew[i]) begin
                errors++;
                $display("FAIL store%0d bus: wr=%b rd=%b addr=%h be=%b wd=%h, required 1 0 bfc00010 %b %h",
                         i, owr, ord, oa, ob, ow, be[i], ew[i]);
            end
            checks++;
            if (rc !== 2 || re !== 1'b0 || rdt !== 32'd0 || bc !== 1) begin
                errors++;
                $display("FAIL store%0d rsp: cycle=%0d err=%b rdata=%h buscyc=%0d, required 2 0 0 1", i, rc, re, rdt, bc);
            end
        end
    endtask

    task automatic test_load();
        int rc, bc; logic re, st, rdy, rw, ord, owr; logic [31:0] rdt, oa, ow; logic [3:0] ob;
        logic [1:0]  sz [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ad [5] = '{32'hBFC00012, 32'hBFC00012, 32'hBFC00012, 32'hBFC00010, 32'hBFC00010};
        logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280, 32'hFFFFFF34, 32'h1280FF34};
        for (int i = 0; i < 5; i++) begin
            do_txn(1'b0, sz[i], sg[i], ad[i], 32'd0, 0, 32'h1280FF34, rc, re, rdt, oa, ob, ow, ord, owr, bc, st, rdy, rw);
            checks++;
            if (rc !== 3 || re !== 1'b0 || rdt !== ex[i] || ord !== 1'b1 || oa !== 32'hBFC00010) begin
                errors++;
                $display("FAIL load%0d: cycle=%0d err=%b rdata=%h rd=%b addr=%h, required 3 0 %h 1 bfc00010",
                         i, rc, re, rdt, ord, oa, ex[i]);
            end
        end
    endtask

    task automatic test_stall_back_to_back();
        int rc, bc; logic re, st, rdy, rw, ord, owr; logic [31:0] rdt, oa, ow; logic [3:0] ob;
        do_txn(1'b0, 2'd2, 1'b0, 32'h00001238, 32'd0, 3, 32'hCAFEF00D, rc, re, rdt, oa, ob, ow, ord, owr, bc, st, rdy, rw);
        checks++;
        if (bc !== 4 || st !== 1'b1 || rc !== 6 || rdt !== 32'hCAFEF00D || rdy !== 1'b1) begin
            errors++;
            $display("FAIL stall: buscyc=%0d stable=%b cycle=%0d rdata=%h ready=%b, required 4 1 6 cafef00d 1",
                     bc, st, rc, rdt, rdy);
        end
        do_txn(1'b1, 2'd0, 1'b0, 32'h00000021, 32'h0000005A, 0, 32'd0, rc, re, rdt, oa, ob, ow, ord, owr, bc, st, rdy, rw);
        checks++;
        if (rc !== 2 || ob !== 4'b0010 || ow !== 32'h5A5A5A5A || oa !== 32'h00000020) begin
            errors++;
            $display("FAIL back_to_back: cycle=%0d be=%b wd=%h addr=%h, required 2 0010 5a5a5a5a 00000020", rc, ob, ow, oa);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse_width: rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_errors();
        int rc, bc; logic re, st, rdy, rw, ord, owr; logic [31:0] rdt, oa, ow; logic [3:0] ob;
        do_txn(1'b0, 2'd2, 1'b0, 32'hBFC00002, 32'd0, 0, 32'd0, rc, re, rdt, oa, ob, ow, ord, owr, bc, st, rdy, rw);
        checks++;
        if (rc !== 1 || re !== 1'b1 || bc !== 0 || rdt !== 32'd0) begin
            errors++;
            $display("FAIL misaligned: cycle=%0d err=%b buscyc=%0d rdata=%h, required 1 1 0 0", rc, re, bc, rdt);
        end
        do_txn(1'b1, 2'd3, 1'b0, 32'h00000100, 32'h11, 0, 32'd0, rc, re, rdt, oa, ob, ow, ord, owr, bc, st, rdy, rw);
        checks++;
        if (rc !== 1 || re !== 1'b1 || bc !== 0) begin
            errors++;
            $display("FAIL size3: cycle=%0d err=%b buscyc=%0d, required 1 1 0", rc, re, bc);
        end
        do_txn(1'b0, 2'd2, 1'b0, 32'h00000400, 32'd0, 100, 32'd0, rc, re, rdt, oa, ob, ow, ord, owr, bc, st, rdy, rw);
        checks++;
        if (rc !== 5 || re !== 1'b1 || bc !== 4 || rw !== 1'b0 || rdt !== 32'd0) begin
            errors++;
            $display("FAIL timeout: cycle=%0d err=%b buscyc=%0d rw_at_rsp=%b rdata=%h, required 5 1 4 0 0",
                     rc, re, bc, rw, rdt);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h00000800;
        waitrequest = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; waitrequest = 1'b0;
        checks++;
        if (read !== 1'b0 || write !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rd=%b wr=%b ready=%b rv=%b, required 0 0 1 0", read, write, cmd_ready, rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_rsp: responses=%0d, required 0", seen);
        end
    endtask

    task automatic test_random();
        int rc, bc, erc, ebc; logic re, st, rdy, rw, ord, owr; logic [31:0] rdt, oa, ow; logic [3:0] ob;
        logic wr, sg, bad; logic [1:0] sz; logic [31:0] ad, wd, rd; int ns;
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom_range(0, 3));
            ad = $urandom; wd = $urandom; rd = $urandom; ns = $urandom_range(0, 2);
            if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << (sz == 2'd3 ? 2'd2 : sz)) - 32'd1);
            bad = exp_bad(sz, ad);
            do_txn(wr, sz, sg, ad, wd, ns, rd, rc, re, rdt, oa, ob, ow, ord, owr, bc, st, rdy, rw);
            erc = bad ? 1 : (wr ? ns + 2 : ns + 3);
            ebc = bad ? 0 : ns + 1;
            checks++;
            if (rc !== erc || re !== bad || bc !== ebc || st !== 1'b1 || rdy !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d timing: cycle=%0d err=%b buscyc=%0d stable=%b ready=%b, required %0d %b %0d 1 1",
                         n, rc, re, bc, st, rdy, erc, bad, ebc);
            end
            if (!bad) begin
                checks++;
                if (oa !== (ad & 32'hFFFFFFFC) || ob !== exp_be(sz, ad[1:0]) || ord !== !wr || owr !== wr ||
                    (wr && ow !== exp_wd(sz, wd)) ||
                    rdt !== (wr ? 32'd0 : exp_ld(sz, sg, ad[1:0], rd))) begin
                    errors++;
                    $display("FAIL rand%0d data: addr=%h be=%b wd=%h rdata=%h, required %h %b %h %h",
                             n, oa, ob, ow, rdt, ad & 32'hFFFFFFFC, exp_be(sz, ad[1:0]), exp_wd(sz, wd),
                             wr ? 32'd0 : exp_ld(sz, sg, ad[1:0], rd));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_stall_back_to_back();
        test_errors();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
